// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the layer sequencer.
// Descriptor layout, error codes and FSM state encoding.
package nn_seq_pkg;

  localparam int DIM_W  = 10;
  localparam int ADDR_W = 16;
  localparam int DESC_W = 48;

  localparam int M_LSB    = 0;
  localparam int N_LSB    = 10;
  localparam int K_LSB    = 20;
  localparam int WB_LSB   = 30;
  localparam int LAST_BIT = 46;
  localparam int RSVD_BIT = 47;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ZERO_DIM = 2'd1;
  localparam logic [1:0] ERR_CHAIN    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_MM,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_e;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] w_base;
    logic [DIM_W-1:0]  k;
    logic [DIM_W-1:0]  n;
    logic [DIM_W-1:0]  m;
  } desc_t;

  function automatic desc_t unpack_desc(
    input logic [LAST_BIT:0] d
  );
    desc_t r;
    r.m      = d[M_LSB +: DIM_W];
    r.n      = d[N_LSB +: DIM_W];
    r.k      = d[K_LSB +: DIM_W];
    r.w_base = d[WB_LSB +: ADDR_W];
    r.last   = d[LAST_BIT];
    return r;
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_timeout.sv
// Engine watchdog: counts enabled cycles since the last clear.
// Ports: clear, enable in; expired high once TIMEOUT_CYCLES-1 is reached.
module seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Steps the matmul engine through a descriptor table, one layer at a time.
// Ports: run/abort/busy/done/err status, descriptor read, engine control.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int MAX_LAYERS     = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int DESC_LAT       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic [$clog2(MAX_LAYERS)-1:0] layer_idx,
  output logic [$clog2(MAX_LAYERS)-1:0] desc_addr,
  input  logic [DESC_W-1:0]             desc_data,
  output logic                          mm_start,
  output logic [DIM_W-1:0]              mm_m,
  output logic [DIM_W-1:0]              mm_n,
  output logic [DIM_W-1:0]              mm_k,
  output logic [ADDR_W-1:0]             mm_w_base,
  output logic                          mm_in_bank,
  output logic                          mm_out_bank,
  input  logic                          mm_done
);

  localparam int LW = $clog2(MAX_LAYERS);
  localparam logic [LW-1:0] IDX_LAST =
    LW'(MAX_LAYERS - 1);
  localparam logic [1:0] FETCH_LAST =
    2'(DESC_LAT - 1);

  state_e            state_q, state_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic              bank_q, bank_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  desc_t             lay_q, lay_d;
  logic [DIM_W-1:0]  pm_q, pm_d;
  logic [DIM_W-1:0]  pn_q, pn_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic              done_prev_q;
  logic              mm_rise;
  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_exp;
  logic              unused_rsvd;

  assign unused_rsvd = desc_data[RSVD_BIT];

  // Only a fresh edge counts; a level left over
  // from the previous layer is already in done_prev_q.
  assign mm_rise = mm_done && !done_prev_q;
  assign tmo_en  = (state_q == S_WAIT_MM);

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clr),
    .enable (tmo_en),
    .expired(tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bank_d  = bank_q;
    err_d   = err_q;
    code_d  = code_q;
    lay_d   = lay_q;
    pm_d    = pm_q;
    pn_d    = pn_q;
    fcnt_d  = '0;
    tmo_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          idx_d   = '0;
          bank_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      S_FETCH: begin
        if (fcnt_q == FETCH_LAST) begin
          lay_d   = unpack_desc(
                      desc_data[LAST_BIT:0]);
          state_d = S_CHECK;
        end else begin
          fcnt_d = fcnt_q + 2'd1;
        end
      end
      S_CHECK: begin
        if (lay_q.m == '0 || lay_q.n == '0 ||
            lay_q.k == '0) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_ZERO_DIM;
        end else if (idx_q != '0 &&
                     (lay_q.k != pn_q ||
                      lay_q.m != pm_q)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_CHAIN;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_clr = 1'b1;
        state_d = S_WAIT_MM;
      end
      S_WAIT_MM: begin
        if (mm_rise) begin
          state_d = S_NEXT;
        end else if (tmo_exp) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end
      S_NEXT: begin
        pm_d   = lay_q.m;
        pn_d   = lay_q.n;
        bank_d = !bank_q;
        // The table end acts as an implicit last bit.
        if (lay_q.last || idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + LW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort freezes everything except the state,
    // so a same-cycle run or error is dropped.
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      bank_d  = bank_q;
      err_d   = err_q;
      code_d  = code_q;
      lay_d   = lay_q;
      pm_d    = pm_q;
      pn_d    = pn_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      bank_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      lay_q       <= '0;
      pm_q        <= '0;
      pn_q        <= '0;
      fcnt_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      err_q       <= err_d;
      code_q      <= code_d;
      lay_q       <= lay_d;
      pm_q        <= pm_d;
      pn_q        <= pn_d;
      fcnt_q      <= fcnt_d;
      done_prev_q <= mm_done;
    end
  end

  assign busy = state_q inside {
    S_FETCH, S_CHECK, S_LAUNCH, S_WAIT_MM, S_NEXT
  };
  assign done     = (state_q == S_DONE) && !abort;
  assign mm_start = (state_q == S_LAUNCH) && !abort;
  assign err      = err_q;
  assign err_code = code_q;

  assign layer_idx = idx_q;
  assign desc_addr = idx_q;

  assign mm_m        = lay_q.m;
  assign mm_n        = lay_q.n;
  assign mm_k        = lay_q.k;
  assign mm_w_base   = lay_q.w_base;
  assign mm_in_bank  = bank_q;
  // Kept as a strict inverse, including at reset.
  assign mm_out_bank = !bank_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer with an engine model.
// Expected events come from a table-walking reference model.
module tb_nn_layer_sequencer;

  localparam int ML  = 4;
  localparam int TMO = 64;
  localparam int DL  = 1;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        run = 0;
  logic        abort = 0;
  logic        mm_done = 0;
  logic        busy, done, err, mm_start;
  logic [1:0]  err_code, layer_idx, desc_addr;
  logic [47:0] desc_data;
  logic [9:0]  mm_m, mm_n, mm_k;
  logic [15:0] mm_w_base;
  logic        mm_in_bank, mm_out_bank;
  logic [47:0] rom [ML];

  assign desc_data = rom[desc_addr];

  nn_layer_sequencer #(
    .MAX_LAYERS(ML),
    .TIMEOUT_CYCLES(TMO),
    .DESC_LAT(DL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .abort(abort), .busy(busy), .done(done),
    .err(err), .err_code(err_code),
    .layer_idx(layer_idx), .desc_addr(desc_addr),
    .desc_data(desc_data), .mm_start(mm_start),
    .mm_m(mm_m), .mm_n(mm_n), .mm_k(mm_k),
    .mm_w_base(mm_w_base), .mm_in_bank(mm_in_bank),
    .mm_out_bank(mm_out_bank), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int a, b, c, d, e;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n_starts = 0;
  int  last_start = 0;
  int  last_done = 0;
  int  eng_mode = 0;
  int  eng_lat = 20;
  int  rise_cyc = 0;

  task automatic chk(input string name,
                     input int act, input int want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, want);
    end
  endtask

  function automatic logic [47:0] mk(
    input int m, input int n, input int k,
    input int wb, input int last, input int rs);
    return {rs[0], last[0], wb[15:0],
            k[9:0], n[9:0], m[9:0]};
  endfunction

  function automatic ev_t ev(input int kind,
    input int a, input int b, input int c,
    input int d, input int e);
    ev_t r;
    r.kind = kind; r.a = a; r.b = b;
    r.c = c; r.d = d; r.e = e;
    return r;
  endfunction

  // kind 0: start(m,n,k,wb,bank) 1: done(bank)
  // kind 2: error(code,layer)
  task automatic model(input int never_done);
    int pm = 0, pn = 0;
    for (int i = 0; i < ML; i++) begin
      logic [47:0] d;
      int m, n, k, wb, last;
      d = rom[i];
      m = int'(d[9:0]);   n = int'(d[19:10]);
      k = int'(d[29:20]); wb = int'(d[45:30]);
      last = int'(d[46]);
      if (m == 0 || n == 0 || k == 0) begin
        exp_q.push_back(ev(2, 1, i, 0, 0, 0));
        return;
      end
      if (i > 0 && (k != pn || m != pm)) begin
        exp_q.push_back(ev(2, 2, i, 0, 0, 0));
        return;
      end
      exp_q.push_back(ev(0, m, n, k, wb, i % 2));
      if (never_done != 0) begin
        exp_q.push_back(ev(2, 3, i, 0, 0, 0));
        return;
      end
      pm = m; pn = n;
      if (last != 0 || i == ML - 1) begin
        exp_q.push_back(ev(1, (i + 1) % 2,
                           0, 0, 0, 0));
        return;
      end
    end
  endtask

  task automatic take(input int kind,
                      output ev_t e, output bit ok);
    ok = 0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event kind %0d at cycle %0d",
               kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  initial begin
    ev_t e;
    bit  ok;
    logic err_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        err_prev = 0;
      end else begin
        if (mm_start) begin
          n_starts++;
          last_start = cyc;
          take(0, e, ok);
          if (ok) begin
            chk("start m", mm_m, e.a);
            chk("start n", mm_n, e.b);
            chk("start k", mm_k, e.c);
            chk("start w_base", mm_w_base, e.d);
            chk("start in_bank", mm_in_bank, e.e);
            chk("start out_bank", mm_out_bank,
                1 - e.e);
          end
        end
        if (done) begin
          last_done = cyc;
          take(1, e, ok);
          if (ok) begin
            chk("done bank", mm_in_bank, e.a);
            chk("done err", err, 0);
            chk("done busy", busy, 0);
          end
        end
        if (err && !err_prev) begin
          take(2, e, ok);
          if (ok) begin
            chk("err code", err_code, e.a);
            chk("err layer", layer_idx, e.b);
            chk("err busy", busy, 0);
            if (e.a == 3)
              chk("timeout latency",
                  cyc - last_start, TMO + 1);
          end
        end
        err_prev = err;
      end
    end
  end

  // Engine: done rises eng_lat cycles after start.
  // Mode 1 never finishes; mode 2 leaves done high
  // across launch, drops it, then raises it again.
  initial begin
    int cnt = 0;
    int stale = 0;
    forever begin
      @(posedge clk); #1;
      if (mm_start) begin
        cnt = eng_lat;
        stale = (eng_mode == 2) ? 5 : 0;
        if (eng_mode != 2) mm_done = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (stale > 0) begin
          stale--;
          if (stale == 0) mm_done = 0;
        end
        if (cnt == 0 && eng_mode != 1) begin
          mm_done = 1;
          rise_cyc = cyc;
        end
      end else if (eng_mode == 2 && !busy) begin
        mm_done = 1;
      end
    end
  end

  int run_cyc = 0;

  task automatic pulse_run();
    @(posedge clk); #1;
    run = 1;
    run_cyc = cyc;
    @(posedge clk); #1;
    run = 0;
  endtask

  task automatic wait_idle(output int end_cyc);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    end_cyc = cyc;
    chk("pass completes", busy, 0);
    repeat (3) @(negedge clk);
    chk("queue drained", exp_q.size(), 0);
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mm_start && n < 200);
    chk("start seen", mm_start, 1);
  endtask

  task automatic run_pass(input int never_done);
    int t;
    model(never_done);
    pulse_run();
    wait_idle(t);
  endtask

  task automatic rand_table();
    int am[ML], an[ML], ak[ML];
    int lastpos, c, j, pn;
    am[0] = $urandom_range(1, 1023);
    pn = $urandom_range(1, 1023);
    for (int i = 0; i < ML; i++) begin
      am[i] = am[0];
      ak[i] = pn;
      an[i] = $urandom_range(1, 1023);
      pn = an[i];
    end
    c = $urandom_range(0, 5);
    j = $urandom_range(0, ML - 1);
    if (c == 0) begin
      case ($urandom_range(0, 2))
        0: am[j] = 0;
        1: an[j] = 0;
        default: ak[j] = 0;
      endcase
    end else if (c == 1 && j > 0) begin
      if ($urandom_range(0, 1) == 0)
        ak[j] = ak[j] ^ 1;
      else
        am[j] = am[j] ^ 2;
    end
    lastpos = $urandom_range(0, ML);
    for (int i = 0; i < ML; i++)
      rom[i] = mk(am[i], an[i], ak[i],
                  $urandom_range(0, 65535),
                  (i == lastpos) ? 1 : 0,
                  $urandom_range(0, 1));
  endtask

  initial begin
    int s0, t, bc;
    for (int i = 0; i < ML; i++) rom[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset err_code", err_code, 0);
    chk("reset layer_idx", layer_idx, 0);
    chk("reset desc_addr", desc_addr, 0);
    chk("reset mm_start", mm_start, 0);
    chk("reset mm_m", mm_m, 0);
    chk("reset mm_w_base", mm_w_base, 0);
    chk("reset in_bank", mm_in_bank, 0);
    chk("reset out_bank", mm_out_bank, 1);
    @(posedge clk); #1 rst_n = 1;

    // Two-layer chain.
    eng_mode = 0; eng_lat = 20;
    rom[0] = mk(1, 4, 3, 16'h0000, 0, 0);
    rom[1] = mk(1, 2, 4, 16'h0010, 1, 0);
    s0 = n_starts;
    run_pass(0);
    chk("chain2 starts", n_starts - s0, 2);
    chk("chain2 final bank", mm_in_bank, 0);
    chk("chain2 err", err, 0);

    // Zero dimension.
    rom[0] = mk(1, 4, 0, 0, 1, 0);
    s0 = n_starts;
    model(0);
    pulse_run();
    wait_idle(t);
    chk("zero-dim busy drop", t - run_cyc, DL + 2);
    chk("zero-dim starts", n_starts - s0, 0);
    chk("zero-dim err_code", err_code, 1);

    // Chain mismatch.
    rom[0] = mk(1, 4, 3, 0, 0, 0);
    rom[1] = mk(1, 2, 5, 16, 1, 0);
    s0 = n_starts;
    run_pass(0);
    chk("mismatch starts", n_starts - s0, 1);
    chk("mismatch err_code", err_code, 2);

    // Timeout, then a clean rerun.
    eng_mode = 1;
    rom[0] = mk(2, 3, 4, 5, 1, 0);
    run_pass(1);
    chk("timeout err", err, 1);
    eng_mode = 0;
    rom[0] = mk(2, 3, 4, 5, 0, 0);
    rom[1] = mk(2, 7, 3, 9, 1, 0);
    model(0);
    pulse_run();
    @(negedge clk);
    chk("rerun clears err", err, 0);
    wait_idle(t);

    // Abort five cycles into WAIT_MM.
    eng_lat = 40;
    rom[0] = mk(1, 4, 3, 0, 0, 0);
    rom[1] = mk(1, 2, 4, 16, 1, 0);
    model(0);
    while (exp_q.size() > 1)
      void'(exp_q.pop_back());
    pulse_run();
    wait_start();
    repeat (5) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort err", err, 0);
    bc = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || done || err) bc++;
    end
    chk("abort stays idle", bc, 0);
    chk("abort queue", exp_q.size(), 0);

    // Run while busy is ignored.
    eng_lat = 20;
    s0 = n_starts;
    model(0);
    pulse_run();
    wait_start();
    @(posedge clk); #1 run = 1;
    @(posedge clk); #1 run = 0;
    @(negedge clk);
    chk("busy run layer_idx", layer_idx, 0);
    chk("busy run busy", busy, 1);
    wait_idle(t);
    chk("busy run starts", n_starts - s0, 2);

    // Run and abort together in IDLE.
    @(posedge clk); #1 run = 1; abort = 1;
    @(posedge clk); #1 run = 0; abort = 0;
    bc = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("run+abort dropped", bc, 0);

    // Stale done held across launch.
    eng_mode = 2;
    repeat (3) @(posedge clk);
    rom[0] = mk(1, 1, 1, 0, 1, 0);
    run_pass(0);
    chk("stale done ignored", last_done,
        rise_cyc + 2);
    eng_mode = 0;

    // Table end without a last bit.
    rom[0] = mk(3, 5, 7, 1, 0, 0);
    rom[1] = mk(3, 6, 5, 2, 0, 0);
    rom[2] = mk(3, 2, 6, 3, 0, 0);
    rom[3] = mk(3, 9, 2, 4, 0, 0);
    s0 = n_starts;
    run_pass(0);
    chk("table end starts", n_starts - s0, ML);

    // Reset in the middle of a pass.
    eng_lat = 40;
    model(0);
    pulse_run();
    wait_start();
    @(posedge clk); #1 rst_n = 0;
    #2;
    chk("midreset busy", busy, 0);
    chk("midreset mm_m", mm_m, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1;
    repeat (45) @(posedge clk);

    // Randomized tables.
    for (int it = 0; it < 24; it++) begin
      rand_table();
      eng_lat = $urandom_range(1, 30);
      eng_mode =
        ($urandom_range(0, 7) == 0) ? 1 : 0;
      run_pass(eng_mode);
      eng_mode = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
